// File: rtl/fpu_lzd_norm_arbiter.sv
// Two-requester arbiter in front of a shared 24-bit leading-zero-detect/normalize pipeline (S1 capture, S2 result).
// Optional round-robin arbitration is enabled by defining FPU_LZD_RR_EN; otherwise A has fixed priority over B.
module fpu_lzd_norm_arbiter #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [MANT_W-1:0] a_mant,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [MANT_W-1:0] b_mant,
    input  logic [EXP_W-1:0]  b_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_mant,
    output logic [EXP_W-1:0]  out_exp,
    output logic [4:0]        out_lz,
    output logic              out_zero,
    output logic              out_uflow,
    output logic              out_src
);

    // Layer 1: 4-bit leading-zero detect, returns {any_one, count}.
    function automatic logic [2:0] lzd_nibble(input logic [3:0] d);
        logic [1:0] cnt;
        casez (d)
            4'b1???: cnt = 2'd0;
            4'b01??: cnt = 2'd1;
            4'b001?: cnt = 2'd2;
            default: cnt = 2'd3;
        endcase
        return {|d, cnt};
    endfunction

    // Layer 2: merge two nibble results into a byte result {any_one, count[2:0]}.
    function automatic logic [3:0] fpu_lzd_mux(input logic [2:0] hi, input logic [2:0] lo);
        logic [3:0] r;
        if (hi[2]) begin
            r = {1'b1, 1'b0, hi[1:0]};
        end else begin
            r = {lo[2], 1'b1, lo[1:0]};
        end
        return r;
    endfunction

    // Layer 3: merge three byte results; byte offsets 0/8/16 become the upper count bits.
    function automatic logic [5:0] lzd_top(input logic [3:0] b2, input logic [3:0] b1, input logic [3:0] b0);
        logic [5:0] r;
        if (b2[3]) begin
            r = {1'b1, 2'b00, b2[2:0]};
        end else if (b1[3]) begin
            r = {1'b1, 2'b01, b1[2:0]};
        end else if (b0[3]) begin
            r = {1'b1, 2'b10, b0[2:0]};
        end else begin
            r = {1'b0, 5'd24};
        end
        return r;
    endfunction

    logic              s1_valid_r;
    logic [MANT_W-1:0] s1_mant_r;
    logic [EXP_W-1:0]  s1_exp_r;
    logic              s1_src_r;

    logic s2_en_s;
    logic s1_en_s;
    logic grant_b_s;
    logic a_hs_s;
    logic b_hs_s;

    assign s2_en_s = !out_valid | out_ready;
    assign s1_en_s = !s1_valid_r | s2_en_s;

`ifdef FPU_LZD_RR_EN
    logic last_src_r;  // 1 = B was granted last, so A wins the next tie

    // Round-robin grant: on contention the source not granted last wins.
    always_comb begin
        if (a_valid && b_valid) begin
            grant_b_s = !last_src_r;
        end else if (b_valid) begin
            grant_b_s = 1'b1;
        end else begin
            grant_b_s = 1'b0;
        end
    end

    // Pointer tracks the last granted source, moving only on a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_src_r <= 1'b1;
        end else if (a_hs_s || b_hs_s) begin
            last_src_r <= b_hs_s;
        end else begin
            last_src_r <= last_src_r;
        end
    end
`else
    assign grant_b_s = !a_valid & b_valid;
`endif

    assign a_ready = s1_en_s & a_valid & !grant_b_s & !rst;
    assign b_ready = s1_en_s & b_valid & grant_b_s & !rst;
    assign a_hs_s  = a_valid & a_ready;
    assign b_hs_s  = b_valid & b_ready;

    // S1 operand capture; an idle advance empties the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_mant_r  <= {MANT_W{1'b0}};
            s1_exp_r   <= {EXP_W{1'b0}};
            s1_src_r   <= 1'b0;
        end else if (s1_en_s) begin
            if (a_hs_s) begin
                s1_valid_r <= 1'b1;
                s1_mant_r  <= a_mant;
                s1_exp_r   <= a_exp;
                s1_src_r   <= 1'b0;
            end else if (b_hs_s) begin
                s1_valid_r <= 1'b1;
                s1_mant_r  <= b_mant;
                s1_exp_r   <= b_exp;
                s1_src_r   <= 1'b1;
            end else begin
                s1_valid_r <= 1'b0;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    logic [5:0][2:0]   nib_s;
    logic [2:0][3:0]   byte_s;
    logic [5:0]        lzd_s;
    logic              mant_zero_s;
    logic [4:0]        lz_s;
    logic [MANT_W-1:0] norm_mant_s;
    logic [EXP_W:0]    exp_wide_s;
    logic [EXP_W-1:0]  exp_out_s;
    logic              uflow_s;

    // Three-layer LZD tree over the S1 mantissa.
    always_comb begin
        nib_s  = {6{3'b000}};
        byte_s = {3{4'b0000}};
        for (int i = 0; i < 6; i++) begin
            nib_s[i] = lzd_nibble(s1_mant_r[4*i +: 4]);
        end
        for (int j = 0; j < 3; j++) begin
            byte_s[j] = fpu_lzd_mux(nib_s[2*j+1], nib_s[2*j]);
        end
        lzd_s = lzd_top(byte_s[2], byte_s[1], byte_s[0]);
    end

    assign mant_zero_s = !lzd_s[5];
    assign lz_s        = lzd_s[4:0];
    assign norm_mant_s = s1_mant_r << lz_s;
    // Underflow is judged on the unwrapped difference so a wrap past -512 still flags it.
    assign exp_wide_s  = {s1_exp_r[EXP_W-1], s1_exp_r} - {{(EXP_W-4){1'b0}}, lz_s};
    assign exp_out_s   = mant_zero_s ? s1_exp_r : exp_wide_s[EXP_W-1:0];
    assign uflow_s     = !mant_zero_s & (exp_wide_s[EXP_W] | (exp_wide_s == {(EXP_W+1){1'b0}}));

    // S2 result register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mant  <= {MANT_W{1'b0}};
            out_exp   <= {EXP_W{1'b0}};
            out_lz    <= 5'd0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
            out_src   <= 1'b0;
        end else if (s2_en_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_mant  <= norm_mant_s;
                out_exp   <= exp_out_s;
                out_lz    <= lz_s;
                out_zero  <= mant_zero_s;
                out_uflow <= uflow_s;
                out_src   <= s1_src_r;
            end else begin
                out_mant  <= out_mant;
                out_exp   <= out_exp;
                out_lz    <= out_lz;
                out_zero  <= out_zero;
                out_uflow <= out_uflow;
                out_src   <= out_src;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_fpu_lzd_norm_arbiter.sv
// Self-checking bench for fpu_lzd_norm_arbiter: directed literal checks plus a queue-based reference model.
module tb_fpu_lzd_norm_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [23:0] a_mant, b_mant;
    logic [9:0]  a_exp, b_exp;
    logic        out_valid, out_ready;
    logic [23:0] out_mant;
    logic [9:0]  out_exp;
    logic [4:0]  out_lz;
    logic        out_zero, out_uflow, out_src;

    always #5 clk = ~clk;

    fpu_lzd_norm_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_mant(a_mant), .a_exp(a_exp),
        .b_valid(b_valid), .b_ready(b_ready), .b_mant(b_mant), .b_exp(b_exp),
        .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
        .out_exp(out_exp), .out_lz(out_lz), .out_zero(out_zero),
        .out_uflow(out_uflow), .out_src(out_src)
    );

    typedef struct packed {
        logic        src;
        logic [23:0] mant;
        logic [9:0]  exp;
    } op_t;

    typedef struct packed {
        logic [4:0]  lz;
        logic [23:0] mant;
        logic [9:0]  exp;
        logic        zero;
        logic        uflow;
    } res_t;

    op_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_push   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Normalization defined arithmetically: find the top set bit by scanning.
    function automatic res_t ref_norm(input logic [23:0] m, input logic [9:0] e);
        res_t r;
        int   n;
        int   se;
        n = 24;
        for (int i = 0; i < 24; i++) if (m[i]) n = 23 - i;
        se      = int'($signed(e));
        r.lz    = 5'(n);
        r.zero  = (m == 24'd0);
        r.mant  = r.zero ? 24'd0 : 24'(m << n);
        r.exp   = r.zero ? e : 10'(se - n);
        r.uflow = !r.zero && ((se - n) <= 0);
        return r;
    endfunction

    logic        hold_v = 1'b0;
    logic [23:0] hold_mant;
    logic [17:0] hold_rest;

    // Compare process: scoreboard against the model every cycle away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            chk("one_grant", 32'(a_ready && b_ready), 32'd0);
            if (hold_v) begin
                chk("stable_mant", 32'(out_mant), 32'(hold_mant));
                chk("stable_rest", 32'({out_valid, out_exp, out_lz, out_zero, out_uflow, out_src}),
                    32'({1'b1, hold_rest}));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    res_t r;
                    r = ref_norm(q[0].mant, q[0].exp);
                    chk("mon_src", 32'(out_src), 32'(q[0].src));
                    chk("mon_lz", 32'(out_lz), 32'(r.lz));
                    chk("mon_mant", 32'(out_mant), 32'(r.mant));
                    chk("mon_exp", 32'(out_exp), 32'(r.exp));
                    chk("mon_flags", 32'({out_zero, out_uflow}), 32'({r.zero, r.uflow}));
                    if (out_ready) void'(q.pop_front());
                end
            end
            hold_v    = out_valid && !out_ready;
            hold_mant = out_mant;
            hold_rest = {out_exp, out_lz, out_zero, out_uflow, out_src};
            if (a_valid && a_ready) begin q.push_back({1'b0, a_mant, a_exp}); n_push++; end
            if (b_valid && b_ready) begin q.push_back({1'b1, b_mant, b_exp}); n_push++; end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic src, input logic [23:0] m, input logic [9:0] e);
        logic ok;
        ok = 1'b0;
        if (src) begin b_valid = 1'b1; b_mant = m; b_exp = e; end
        else begin a_valid = 1'b1; a_mant = m; a_exp = e; end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = src ? b_ready : a_ready;
            tick();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk("send_handshake", 32'(ok), 32'd1);
    endtask

    task automatic expect_out(input string name, input logic [4:0] lz, input logic [23:0] m,
                              input logic [9:0] e, input logic z, input logic u, input logic s);
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_lz"}, 32'(out_lz), 32'(lz));
        chk({name, "_mant"}, 32'(out_mant), 32'(m));
        chk({name, "_exp"}, 32'(out_exp), 32'(e));
        chk({name, "_zero_uflow_src"}, 32'({out_zero, out_uflow, out_src}), 32'({z, u, s}));
        tick();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk({name, "_drained"}, 32'(q.size()), 32'd0);
        tick();
    endtask

    int          acc;
    int          idx;
    int          gs;
    int          start;
    logic [23:0] pm [5];
    logic [9:0]  pe [5];

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        a_valid = 1'b1; a_mant = 24'h00F000; a_exp = 10'd10;
        b_valid = 1'b0; b_mant = 24'd0; b_exp = 10'd0;

        // Model pinned to hand-computed values.
        chk("model_lz_f000", 32'(ref_norm(24'h00F000, 10'd10).lz), 32'd8);
        chk("model_exp_lsb", 32'(ref_norm(24'h000001, 10'd3).exp), 32'h3EC);

        repeat (2) begin
            @(negedge clk);
            chk("rst_a_ready", 32'(a_ready), 32'd0);
            chk("rst_out_mant", 32'(out_mant), 32'd0);
            chk("rst_out_rest", 32'({out_valid, out_exp, out_lz, out_zero, out_uflow, out_src}), 32'd0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_a_ready", 32'(a_ready), 32'd1);
        tick();
        a_valid = 1'b0;
        @(negedge clk);
        chk("latency_s1_only", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("single_a_lz", 32'(out_lz), 32'd8);
        chk("single_a_mant", 32'(out_mant), 32'hF00000);
        chk("single_a_exp", 32'(out_exp), 32'd2);
        chk("single_a_src_uflow", 32'({out_src, out_uflow, out_zero}), 32'd0);
        tick();

        send_op(1'b0, 24'h000000, 10'd5);
        expect_out("zero", 5'd24, 24'h000000, 10'd5, 1'b1, 1'b0, 1'b0);
        send_op(1'b1, 24'h000001, 10'd3);
        expect_out("lsb", 5'd23, 24'h800000, 10'h3EC, 1'b0, 1'b1, 1'b1);
        send_op(1'b0, 24'h800000, 10'd7);
        expect_out("msb", 5'd0, 24'h800000, 10'd7, 1'b0, 1'b0, 1'b0);
        send_op(1'b0, 24'h400000, 10'h200);
        expect_out("wrap", 5'd1, 24'h800000, 10'h1FF, 1'b0, 1'b1, 1'b0);

        // Contention after a fresh reset so the pointer starts favouring A.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_valid = 1'b1; a_mant = 24'h001234; a_exp = 10'd40;
        b_valid = 1'b1; b_mant = 24'h0000F0; b_exp = 10'd30;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            gs = b_ready ? 1 : (a_ready ? 0 : 2);
`ifdef FPU_LZD_RR_EN
            chk($sformatf("contend_grant_%0d", i), 32'(gs), 32'(i % 2));
`else
            chk($sformatf("contend_grant_%0d", i), 32'(gs), 32'd0);
`endif
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        drain("contend");

        // Backpressure: five ops offered, consumer stalled for four cycles.
        pm[0] = 24'h000F00; pm[1] = 24'h3C0000; pm[2] = 24'h000002; pm[3] = 24'h0A0000; pm[4] = 24'h00007F;
        pe[0] = 10'd20; pe[1] = 10'd1; pe[2] = 10'd100; pe[3] = 10'h3F0; pe[4] = 10'd9;
        out_ready = 1'b0; idx = 0; acc = 0;
        a_valid = 1'b1; a_mant = pm[0]; a_exp = pe[0];
        for (int c = 0; c < 44 && idx < 5; c++) begin
            logic hs;
            if (c == 4) begin
                chk("bp_accepted_while_stalled", 32'(acc), 32'd2);
                out_ready = 1'b1;
            end
            @(negedge clk);
            hs = a_ready;
            if (hs) acc++;
            tick();
            if (hs) begin
                idx++;
                if (idx < 5) begin a_mant = pm[idx]; a_exp = pe[idx]; end
                else a_valid = 1'b0;
            end
        end
        a_valid = 1'b0;
        chk("bp_all_accepted", 32'(idx), 32'd5);
        drain("bp");

        // Random valid/ready traffic against the model.
        start = n_push;
        for (int c = 0; c < 60000 && (n_push - start) < 10000; c++) begin
            a_valid   = ($urandom_range(0, 3) != 0);
            b_valid   = ($urandom_range(0, 3) != 0);
            a_mant    = 24'($urandom) >> $urandom_range(0, 24);
            b_mant    = 24'($urandom) >> $urandom_range(0, 24);
            a_exp     = 10'($urandom);
            b_exp     = 10'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
        chk("rand_ops_done", 32'((n_push - start) >= 10000), 32'd1);
        drain("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
